// File: rtl/exe_decode_pipe.sv
// Execute-decode stage: per-lane uop decode and immediate expansion,
// held in a 2-entry bundle buffer with valid/ready handshakes.
package exe_decode_pkg;

    localparam int UOPC_W = 5;

    localparam logic [4:0] UOP_LUI   = 5'd0;
    localparam logic [4:0] UOP_AUIPC = 5'd1;
    localparam logic [4:0] UOP_JALR  = 5'd2;
    localparam logic [4:0] UOP_BEQ   = 5'd3;
    localparam logic [4:0] UOP_BNE   = 5'd4;
    localparam logic [4:0] UOP_BLT   = 5'd5;
    localparam logic [4:0] UOP_BGE   = 5'd6;
    localparam logic [4:0] UOP_BLTU  = 5'd7;
    localparam logic [4:0] UOP_BGEU  = 5'd8;
    localparam logic [4:0] UOP_ADDI  = 5'd9;
    localparam logic [4:0] UOP_SLTI  = 5'd10;
    localparam logic [4:0] UOP_SLTIU = 5'd11;
    localparam logic [4:0] UOP_XORI  = 5'd12;
    localparam logic [4:0] UOP_ORI   = 5'd13;
    localparam logic [4:0] UOP_ANDI  = 5'd14;
    localparam logic [4:0] UOP_SLLI  = 5'd15;
    localparam logic [4:0] UOP_SRLI  = 5'd16;
    localparam logic [4:0] UOP_SRAI  = 5'd17;
    localparam logic [4:0] UOP_ADD   = 5'd18;
    localparam logic [4:0] UOP_SUB   = 5'd19;
    localparam logic [4:0] UOP_SLL   = 5'd20;
    localparam logic [4:0] UOP_SLT   = 5'd21;
    localparam logic [4:0] UOP_SLTU  = 5'd22;
    localparam logic [4:0] UOP_XOR   = 5'd23;
    localparam logic [4:0] UOP_SRL   = 5'd24;
    localparam logic [4:0] UOP_SRA   = 5'd25;
    localparam logic [4:0] UOP_OR    = 5'd26;
    localparam logic [4:0] UOP_AND   = 5'd27;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alufn_e;
    typedef enum logic [1:0] {OPR1_ZERO, OPR1_RS1, OPR1_PC} opr1_e;
    typedef enum logic {OPR2_IMM, OPR2_RS2} opr2_e;
    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JALR
    } brfn_e;

    typedef struct packed {
        alufn_e alufn;
        opr1_e  opr1;
        opr2_e  opr2;
        brfn_e  brfn;
        logic   illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_DEF = '{ALU_ADD, OPR1_ZERO, OPR2_IMM, BR_NONE, 1'b0};

    function automatic ctrl_t ctl(input alufn_e a, input opr1_e o1,
                                  input opr2_e o2, input brfn_e b);
        return '{a, o1, o2, b, 1'b0};
    endfunction

    function automatic ctrl_t decode(input logic [4:0] uopc, input logic v);
        ctrl_t c;
        c = CTRL_DEF;
        case (uopc)
            UOP_LUI:   c = CTRL_DEF;
            UOP_AUIPC: c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_NONE);
            UOP_JALR:  c = ctl(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_JALR);
            UOP_BEQ:   c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_EQ);
            UOP_BNE:   c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_NE);
            UOP_BLT:   c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_LT);
            UOP_BGE:   c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_GE);
            UOP_BLTU:  c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_LTU);
            UOP_BGEU:  c = ctl(ALU_ADD, OPR1_PC, OPR2_IMM, BR_GEU);
            UOP_ADDI:  c = ctl(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_SLTI:  c = ctl(ALU_SLT, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_SLTIU: c = ctl(ALU_SLTU, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_XORI:  c = ctl(ALU_XOR, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_ORI:   c = ctl(ALU_OR, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_ANDI:  c = ctl(ALU_AND, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_SLLI:  c = ctl(ALU_SLL, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_SRLI:  c = ctl(ALU_SRL, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_SRAI:  c = ctl(ALU_SRA, OPR1_RS1, OPR2_IMM, BR_NONE);
            UOP_ADD:   c = ctl(ALU_ADD, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SUB:   c = ctl(ALU_SUB, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SLL:   c = ctl(ALU_SLL, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SLT:   c = ctl(ALU_SLT, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SLTU:  c = ctl(ALU_SLTU, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_XOR:   c = ctl(ALU_XOR, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SRL:   c = ctl(ALU_SRL, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_SRA:   c = ctl(ALU_SRA, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_OR:    c = ctl(ALU_OR, OPR1_RS1, OPR2_RS2, BR_NONE);
            UOP_AND:   c = ctl(ALU_AND, OPR1_RS1, OPR2_RS2, BR_NONE);
            default:   c.illegal = v;
        endcase
        return c;
    endfunction

    // Packed layout keeps the sign in p[19] for every format.
    function automatic logic [31:0] expand_imm(input logic [19:0] p,
                                               input imm_type_e t);
        case (t)
            IMM_B:   return {{20{p[19]}}, p[8], p[18:13], p[12:9], 1'b0};
            IMM_J:   return {{12{p[19]}}, p[7:0], p[8], p[18:9], 1'b0};
            IMM_U:   return {p, 12'h000};
            default: return {{20{p[19]}}, p[19:8]};
        endcase
    endfunction

endpackage

module exe_decode_pipe
    import exe_decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_lane_v,
    input  logic [LANES-1:0][UOPC_W-1:0] in_uopc,
    input  logic [LANES-1:0][19:0]       in_imm_packed,
    input  imm_type_e [LANES-1:0]        in_imm_type,
    input  logic [LANES-1:0][31:0]       in_pc,
    input  logic [LANES-1:0][TAG_W-1:0]  in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0]             out_lane_v,
    output logic [LANES-1:0][31:0]       out_pc,
    output logic [LANES-1:0][TAG_W-1:0]  out_tag,
    output alufn_e [LANES-1:0]           out_alufn,
    output opr1_e [LANES-1:0]            out_opr1,
    output opr2_e [LANES-1:0]            out_opr2,
    output brfn_e [LANES-1:0]            out_brfn,
    output logic [LANES-1:0][31:0]       out_imm,
    output logic [LANES-1:0]             out_illegal,
    output logic [CNT_W-1:0]             illegal_cnt
);

    ctrl_t [LANES-1:0]             dec_ctrl;
    logic  [LANES-1:0][31:0]       dec_imm;

    ctrl_t [LANES-1:0]             mem_ctrl [2];
    logic  [LANES-1:0][31:0]       mem_imm  [2];
    logic  [LANES-1:0][31:0]       mem_pc   [2];
    logic  [LANES-1:0][TAG_W-1:0]  mem_tag  [2];
    logic  [LANES-1:0]             mem_v    [2];

    logic [1:0]   cnt;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;
    logic [2:0]   ill_pop;
    logic [CNT_W:0] ill_sum;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign dec_ctrl[i]    = decode(in_uopc[i], in_lane_v[i]);
        assign dec_imm[i]     = expand_imm(in_imm_packed[i], in_imm_type[i]);
        assign out_alufn[i]   = mem_ctrl[rd_ptr][i].alufn;
        assign out_opr1[i]    = mem_ctrl[rd_ptr][i].opr1;
        assign out_opr2[i]    = mem_ctrl[rd_ptr][i].opr2;
        assign out_brfn[i]    = mem_ctrl[rd_ptr][i].brfn;
        assign out_illegal[i] = mem_ctrl[rd_ptr][i].illegal;
    end

    assign out_lane_v = mem_v[rd_ptr];
    assign out_pc     = mem_pc[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];
    assign out_imm    = mem_imm[rd_ptr];

    always_comb begin
        ill_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            ill_pop = ill_pop + 3'(dec_ctrl[i].illegal);
        end
    end

    assign ill_sum = {1'b0, illegal_cnt} + (CNT_W+1)'(ill_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                mem_v[e]   <= '0;
                mem_imm[e] <= '0;
                mem_pc[e]  <= '0;
                mem_tag[e] <= '0;
                for (int l = 0; l < LANES; l++) begin
                    mem_ctrl[e][l] <= CTRL_DEF;
                end
            end
        end else if (flush) begin
            cnt    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_ctrl[wr_ptr] <= dec_ctrl;
                mem_imm[wr_ptr]  <= dec_imm;
                mem_pc[wr_ptr]   <= in_pc;
                mem_tag[wr_ptr]  <= in_tag;
                mem_v[wr_ptr]    <= in_lane_v;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push) begin
            illegal_cnt <= ill_sum[CNT_W] ? '1 : ill_sum[CNT_W-1:0];
        end
    end

endmodule
